// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory port: ls_type field layout,
// access size codes, arbiter state encoding and the fetch fallback word.
package mem_pkg;

    localparam int unsigned LS_SIZE_LSB = 0;
    localparam int unsigned LS_SIZE_MSB = 1;
    localparam int unsigned LS_UNS_BIT  = 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_ME,
        BUSY_IF
    } arb_state_e;

endpackage

// File: rtl/ls_format.sv
// Load/store lane formatting: byte enables, store replication, misalign
// detection on the request side and load byte/half extraction on the response side.
module ls_format
    import mem_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    output logic        req_misalign_o,

    input  logic [1:0]  rsp_size_i,
    input  logic        rsp_unsigned_i,
    input  logic [1:0]  rsp_addr_lo_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        req_be_o       = 4'b1111;
        req_wdata_o    = req_wdata_i;
        req_misalign_o = 1'b0;
        case (req_size_i)
            SZ_B: begin
                req_be_o    = 4'b0001 << req_addr_lo_i;
                req_wdata_o = {4{req_wdata_i[7:0]}};
            end
            SZ_H: begin
                req_be_o       = 4'b0011 << {req_addr_lo_i[1], 1'b0};
                req_wdata_o    = {2{req_wdata_i[15:0]}};
                req_misalign_o = req_addr_lo_i[0];
            end
            // Word and the unused size code both behave as a full word.
            default: begin
                req_misalign_o = |req_addr_lo_i;
            end
        endcase
    end

    always_comb begin
        case (rsp_addr_lo_i)
            2'd0:    byte_sel = rsp_rdata_i[7:0];
            2'd1:    byte_sel = rsp_rdata_i[15:8];
            2'd2:    byte_sel = rsp_rdata_i[23:16];
            default: byte_sel = rsp_rdata_i[31:24];
        endcase
        half_sel = rsp_addr_lo_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];

        rsp_load_o = rsp_rdata_i;
        case (rsp_size_i)
            SZ_B: rsp_load_o = rsp_unsigned_i ? {24'b0, byte_sel}
                                              : {{24{byte_sel[7]}}, byte_sel};
            SZ_H: rsp_load_o = rsp_unsigned_i ? {16'b0, half_sel}
                                              : {{16{half_sel[15]}}, half_sel};
            default: rsp_load_o = rsp_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the single memory port shared by instruction fetch
// and the M-stage load/store unit, with per-access timeout and fetch flush.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [31:0]       if_rdata,

    input  logic              me_req,
    input  logic              me_we,
    input  logic [3:0]        me_ls_type,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [31:0]       me_wdata,
    output logic              me_done,
    output logic [31:0]       me_rdata,
    output logic              me_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,

    output logic              stall_if,
    output logic              stall_me
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic              last_me_q, last_me_d;
    logic              discard_q, discard_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [1:0]        rsp_size_q, rsp_size_d;
    logic              rsp_uns_q, rsp_uns_d;
    logic [1:0]        rsp_lo_q, rsp_lo_d;

    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              me_done_q, me_done_d;
    logic [31:0]       me_rdata_q, me_rdata_d;
    logic              me_err_q, me_err_d;

    logic              me_elig, if_elig, timed_out;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata, rsp_load;
    logic              req_misalign;
    logic              unused_bits;

    assign unused_bits = ^{if_addr[1:0], me_ls_type[3]};

    ls_format u_ls_format (
        .req_size_i     (me_ls_type[LS_SIZE_MSB:LS_SIZE_LSB]),
        .req_addr_lo_i  (me_addr[1:0]),
        .req_wdata_i    (me_wdata),
        .req_be_o       (req_be),
        .req_wdata_o    (req_wdata),
        .req_misalign_o (req_misalign),
        .rsp_size_i     (rsp_size_q),
        .rsp_unsigned_i (rsp_uns_q),
        .rsp_addr_lo_i  (rsp_lo_q),
        .rsp_rdata_i    (mem_rdata),
        .rsp_load_o     (rsp_load)
    );

    // A requester sits out the cycle its own completion pulse is visible,
    // since it has not yet had a chance to drop or replace its request.
    assign me_elig   = me_req & ~me_done_q;
    assign if_elig   = if_req & ~if_valid_q;
    assign timed_out = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        last_me_d   = last_me_q;
        discard_d   = discard_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_size_d  = rsp_size_q;
        rsp_uns_d   = rsp_uns_q;
        rsp_lo_d    = rsp_lo_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        me_done_d   = 1'b0;
        me_rdata_d  = me_rdata_q;
        me_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (me_elig && (!if_elig || !last_me_q)) begin
                    last_me_d = 1'b1;
                    if (req_misalign) begin
                        me_done_d  = 1'b1;
                        me_err_d   = 1'b1;
                        me_rdata_d = '0;
                    end else begin
                        state_d     = BUSY_ME;
                        wait_d      = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = me_we;
                        mem_be_d    = req_be;
                        mem_addr_d  = {me_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = req_wdata;
                        rsp_size_d  = me_ls_type[LS_SIZE_MSB:LS_SIZE_LSB];
                        rsp_uns_d   = me_ls_type[LS_UNS_BIT];
                        rsp_lo_d    = me_addr[1:0];
                    end
                end else if (if_elig) begin
                    last_me_d   = 1'b0;
                    state_d     = BUSY_IF;
                    wait_d      = '0;
                    discard_d   = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'b1111;
                    mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = '0;
                end
            end

            BUSY_ME: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    me_done_d  = 1'b1;
                    me_rdata_d = mem_we_q ? '0 : rsp_load;
                end else if (timed_out) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    me_done_d  = 1'b1;
                    me_err_d   = 1'b1;
                    me_rdata_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            BUSY_IF: begin
                if (if_flush) begin
                    discard_d = 1'b1;
                end
                // A flush in the completing cycle must also suppress the pulse.
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!(discard_q || if_flush)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (timed_out) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!(discard_q || if_flush)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = NOP;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_me_q   <= 1'b0;
            discard_q   <= 1'b0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_size_q  <= '0;
            rsp_uns_q   <= 1'b0;
            rsp_lo_q    <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            me_done_q   <= 1'b0;
            me_rdata_q  <= '0;
            me_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_me_q   <= last_me_d;
            discard_q   <= discard_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_size_q  <= rsp_size_d;
            rsp_uns_q   <= rsp_uns_d;
            rsp_lo_q    <= rsp_lo_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            me_done_q   <= me_done_d;
            me_rdata_q  <= me_rdata_d;
            me_err_q    <= me_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign me_done   = me_done_q;
    assign me_rdata  = me_rdata_q;
    assign me_err    = me_err_q;

    assign stall_if  = if_req & ~if_valid_q;
    assign stall_me  = me_req & ~me_done_q;

endmodule
